pulse_count_ctrl: RTL and testbench

Run controller for the serial-data event counter. It accepts a run configuration (hit threshold, idle timeout, auto re-arm) through a valid/ready handshake. It sequences a run: start, count cycles with data=1, raise a one-cycle flag on reaching the threshold, then re-arm or return to idle. It sits between the host control logic and the data-sampling path, and supersedes the fixed count-of-5 flag machine.

---
 rtl/pcc_pkg.sv | 17 +
 rtl/pcc_idle_timer.sv | 48 ++++
 rtl/pulse_count_ctrl.sv | 151 +++++++++++++++
 tb/tb_pulse_count_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pcc_pkg.sv
// Shared definitions for the pulse-count run controller.
//   pcc_state_e  : run-controller FSM state encoding
//   DEF_*        : configuration values restored by reset
package pcc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HIT   = 2'd2,
    ST_ERR   = 2'd3
  } pcc_state_e;

  localparam int unsigned DEF_THRESH  = 5;
  localparam int unsigned DEF_TIMEOUT = 0;
  localparam logic        DEF_AUTO    = 1'b0;

endpackage : pcc_pkg

// File: rtl/pcc_idle_timer.sv
// Idle timer for the run controller: counts consecutive data=0 cycles and
// reports when the configured timeout has been reached.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   clr_i    : clear the timer (takes priority over inc_i)
//   inc_i    : advance the timer by one
//   timeout_i: latched timeout value; 0 disables the timer
//   expired_o: timer holds timeout-1, so one more idle cycle ends the run
module pcc_idle_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [TMO_W-1:0] timeout_i,
  output logic             expired_o
);

  localparam logic [TMO_W-1:0] T_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] timer_q;
  logic [TMO_W-1:0] timer_d;
  logic             enabled;

  assign enabled   = (timeout_i != '0);
  // timeout_i - 1 wraps when timeout_i is 0; the enable term masks that case.
  assign expired_o = enabled && (timer_q == (timeout_i - T_ONE));

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (inc_i && enabled && !expired_o) begin
      // Holding while disabled keeps the timer from wrapping on long idle runs.
      timer_d = timer_q + T_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule : pcc_idle_timer

// File: rtl/pulse_count_ctrl.sv
// Run controller for the serial-data event counter. Accepts a run
// configuration via valid/ready, counts data=1 cycles, pulses flag when the
// threshold is reached, optionally re-arms, and pulses timeout_err when data
// stays low too long.
//   clk, rst                : clock and asynchronous active-high reset
//   cfg_valid / cfg_ready   : configuration handshake (ready only in IDLE)
//   cfg_thresh/timeout/auto : configuration payload
//   start, abort            : run control
//   data                    : sampled serial input
//   flag, timeout_err       : one-cycle event pulses
//   busy, count             : run status
module pulse_count_ctrl
  import pcc_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             cfg_auto,
  input  logic             start,
  input  logic             abort,
  input  logic             data,
  output logic             flag,
  output logic             timeout_err,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pcc_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] thresh_q;
  logic [TMO_W-1:0] timeout_q;
  logic             auto_q;

  logic [CNT_W-1:0] eff_thresh;
  logic             cfg_accept;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_expired;

  assign cfg_ready  = (state_q == ST_IDLE);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign eff_thresh = (thresh_q == '0) ? C_ONE : thresh_q;

  // Configuration only changes while idle, so it is stable for a whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh_q  <= CNT_W'(DEF_THRESH);
      timeout_q <= TMO_W'(DEF_TIMEOUT);
      auto_q    <= DEF_AUTO;
    end else if (cfg_accept) begin
      thresh_q  <= cfg_thresh;
      timeout_q <= cfg_timeout;
      auto_q    <= cfg_auto;
    end
  end

  pcc_idle_timer #(
    .TMO_W(TMO_W)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .timeout_i(timeout_q),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    if (abort) begin
      // Leaving HIT/ERR un-entered is what suppresses the pending pulse.
      state_d = ST_IDLE;
      count_d = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_COUNT;
            count_d = '0;
            tmr_clr = 1'b1;
          end
        end
        ST_COUNT: begin
          if (data) begin
            tmr_clr = 1'b1;
            if (count_q == (eff_thresh - C_ONE)) begin
              state_d = ST_HIT;
              count_d = eff_thresh;
            end else begin
              count_d = count_q + C_ONE;
            end
          end else if (tmr_expired) begin
            state_d = ST_ERR;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_HIT: begin
          tmr_clr = 1'b1;
          if (auto_q) begin
            // The HIT-cycle sample starts the next run; with a threshold of
            // one it completes that run immediately.
            if (data && (eff_thresh == C_ONE)) begin
              state_d = ST_HIT;
              count_d = C_ONE;
            end else begin
              state_d = ST_COUNT;
              count_d = {{(CNT_W-1){1'b0}}, data};
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ERR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign flag        = (state_q == ST_HIT);
  assign timeout_err = (state_q == ST_ERR);
  assign busy        = (state_q != ST_IDLE);
  assign count       = count_q;

endmodule : pulse_count_ctrl

// File: tb/tb_pulse_count_ctrl.sv
// Directed, table-driven bench for pulse_count_ctrl.
module tb_pulse_count_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_thresh;
  logic [15:0] cfg_timeout;
  logic        cfg_auto;
  logic        start;
  logic        abort;
  logic        data;
  logic        flag;
  logic        timeout_err;
  logic        busy;
  logic [7:0]  count;

  int checks = 0;
  int errors = 0;

  pulse_count_ctrl #(
    .CNT_W(8),
    .TMO_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_thresh (cfg_thresh),
    .cfg_timeout(cfg_timeout),
    .cfg_auto   (cfg_auto),
    .start      (start),
    .abort      (abort),
    .data       (data),
    .flag       (flag),
    .timeout_err(timeout_err),
    .busy       (busy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  th;
    logic [15:0] to;
    logic        au;
    logic        st;
    logic        ab;
    logic        d;
    logic        ef;
    logic        et;
    logic        eb;
    logic [7:0]  ec;
    logic        er;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic cv, input logic [7:0] th, input logic [15:0] to,
                     input logic au, input logic st, input logic ab, input logic d,
                     input logic ef, input logic et, input logic eb,
                     input logic [7:0] ec, input logic er);
    vec_t v;
    v.cv = cv; v.th = th; v.to = to; v.au = au; v.st = st; v.ab = ab; v.d = d;
    v.ef = ef; v.et = et; v.eb = eb; v.ec = ec; v.er = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0d required %0d", nm, idx, act, exp);
    end
  endtask

  task automatic expect_all(input int idx, input logic ef, input logic et,
                            input logic eb, input logic [7:0] ec, input logic er);
    chk("flag", idx, 32'(flag), 32'(ef));
    chk("timeout_err", idx, 32'(timeout_err), 32'(et));
    chk("busy", idx, 32'(busy), 32'(eb));
    chk("count", idx, 32'(count), 32'(ec));
    chk("cfg_ready", idx, 32'(cfg_ready), 32'(er));
  endtask

  // Drive inputs mid-cycle, then sample 1ns after the following rising edge.
  task automatic drive(input logic cv, input logic [7:0] th, input logic [15:0] to,
                       input logic au, input logic st, input logic ab, input logic d);
    @(negedge clk);
    cfg_valid = cv; cfg_thresh = th; cfg_timeout = to; cfg_auto = au;
    start = st; abort = ab; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_thresh = '0; cfg_timeout = '0; cfg_auto = 1'b0;
    start = 1'b0; abort = 1'b0; data = 1'b0;

    // ---------------- vector table ----------------
    // A: default config (thresh 5), five ones
    add(0,0,0,0, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,0,1,  0,0,1,2,0);
    add(0,0,0,0, 0,0,1,  0,0,1,3,0);
    add(0,0,0,0, 0,0,1,  0,0,1,4,0);
    add(0,0,0,0, 0,0,1,  1,0,1,5,0);
    add(0,0,0,0, 0,0,0,  0,0,0,5,1);
    // B: cfg with start, thresh 3, pattern 1,0,0,1,0,1
    add(1,3,0,0, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,1,1,0);
    add(0,0,0,0, 0,0,1,  0,0,1,2,0);
    add(0,0,0,0, 0,0,0,  0,0,1,2,0);
    add(0,0,0,0, 0,0,1,  1,0,1,3,0);
    add(0,0,0,0, 0,0,0,  0,0,0,3,1);
    // C: thresh 2 auto re-arm, then abort on the edge that would enter HIT
    add(1,2,0,1, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,0,1,  1,0,1,2,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,0,1,  1,0,1,2,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,1,1,  0,0,0,0,1);
    add(0,0,0,0, 0,0,0,  0,0,0,0,1);
    // D: timeout 3 with data held low
    add(1,5,3,0, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,0,  0,1,1,0,0);
    add(0,0,0,0, 0,0,0,  0,0,0,0,1);
    // D2: a one restarts the idle timer; count holds through ERR
    add(0,0,0,0, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  0,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,1,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,0,1,1);
    // E: thresh 1 auto re-arm gives a flag every cycle
    add(1,1,0,1, 1,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  1,0,1,1,0);
    add(0,0,0,0, 0,0,1,  1,0,1,1,0);
    add(0,0,0,0, 0,0,0,  0,0,1,0,0);
    add(0,0,0,0, 0,0,1,  1,0,1,1,0);
    add(0,0,0,0, 0,1,0,  0,0,0,0,1);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    $display("reset  flag=%b terr=%b busy=%b count=%0d ready=%b",
             flag, timeout_err, busy, count, cfg_ready);
    expect_all(-1, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].cv, vq[i].th, vq[i].to, vq[i].au, vq[i].st, vq[i].ab, vq[i].d);
      $display("vec %0d cv=%b st=%b ab=%b d=%b -> flag=%b terr=%b busy=%b count=%0d ready=%b",
               i, vq[i].cv, vq[i].st, vq[i].ab, vq[i].d,
               flag, timeout_err, busy, count, cfg_ready);
      expect_all(i, vq[i].ef, vq[i].et, vq[i].eb, vq[i].ec, vq[i].er);
    end

    // ---------------- pending cfg during a run, then abort ----------------
    drive(1,5,0,0, 1,0,0); expect_all(100, 0,0,1,0,0);
    drive(0,0,0,0, 0,0,1); expect_all(101, 0,0,1,1,0);
    // thresh 3 offered mid-run must not take effect: third one gives count 3, no flag
    drive(1,3,0,0, 0,0,1); expect_all(102, 0,0,1,2,0);
    drive(1,3,0,0, 0,0,1); expect_all(103, 0,0,1,3,0);
    drive(1,3,0,0, 0,1,0); expect_all(104, 0,0,0,0,1);
    $display("seq abort/pending cfg busy=%b count=%0d ready=%b", busy, count, cfg_ready);
    // accepted now in IDLE together with start; thresh 3 governs
    drive(1,3,0,0, 1,0,0); expect_all(105, 0,0,1,0,0);
    drive(0,0,0,0, 0,0,1); expect_all(106, 0,0,1,1,0);
    drive(0,0,0,0, 0,0,1); expect_all(107, 0,0,1,2,0);
    drive(0,0,0,0, 0,0,1); expect_all(108, 1,0,1,3,0);
    drive(0,0,0,0, 0,0,0); expect_all(109, 0,0,0,3,1);
    $display("seq pending cfg run flag seen, count=%0d", count);

    // ---------------- async reset mid-run ----------------
    drive(0,0,0,0, 1,0,0); expect_all(200, 0,0,1,0,0);
    drive(0,0,0,0, 0,0,1); expect_all(201, 0,0,1,1,0);
    drive(0,0,0,0, 0,0,1); expect_all(202, 0,0,1,2,0);
    #2;
    rst = 1'b1;
    #1;
    $display("seq async rst busy=%b count=%0d ready=%b", busy, count, cfg_ready);
    expect_all(203, 0,0,0,0,1);
    @(negedge clk);
    rst = 1'b0;
    // config defaults restored: thresh 5 again
    drive(0,0,0,0, 1,0,0); expect_all(204, 0,0,1,0,0);
    for (int k = 1; k <= 5; k++) begin
      drive(0,0,0,0, 0,0,1);
      expect_all(204 + k, (k == 5), 0, 1, 8'(k), 0);
    end
    drive(0,0,0,0, 0,0,0); expect_all(210, 0,0,0,5,1);

    // ---------------- thresh 0 behaves as 1 ----------------
    drive(1,0,0,0, 1,0,0); expect_all(300, 0,0,1,0,0);
    drive(0,0,0,0, 0,0,1); expect_all(301, 1,0,1,1,0);
    drive(0,0,0,0, 0,0,0); expect_all(302, 0,0,0,1,1);
    $display("seq thresh0 done count=%0d", count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_count_ctrl
